// File: rtl/bdiv20x10_seq.sv
// Sequential 20-by-10 unsigned restoring divider with valid/ready handshakes.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a dividend/divisor pair (in_ready=1)
//   BUSY  | one restoring step per cycle, 20 steps, dividend MSB first
//   DONE  | result held on Q/R/dbz (out_valid=1) until out_ready
//
// A zero divisor skips BUSY and reports Q=all-ones, R=A[9:0], dbz=1.
// Q/R/dbz are dedicated result registers, so they stay put after the result
// is taken and only change when the next division completes.
module bdiv20x10_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [19:0] A,
   input  logic [9:0]  B,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [19:0] Q,
   output logic [9:0]  R,
   output logic        dbz
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;
   localparam logic [4:0] LAST_STEP = 5'd19;

   logic [1:0]  state_q, state_d;
   logic [19:0] a_q, a_d;       // dividend bits shift out at the top, quotient bits shift in at the bottom
   logic [9:0]  b_q, b_d;
   logic [10:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [19:0] q_q, q_d;
   logic [9:0]  r_q, r_d;
   logic        dbz_q, dbz_d;

   logic [10:0] rem_sh;
   logic        rem_ge;
   logic [10:0] rem_nx;
   logic [19:0] quo_nx;

   // One restoring step: shift in next dividend bit, subtract divisor when it fits.
   always_comb begin
      rem_sh = {rem_q[9:0], a_q[19]};
      rem_ge = rem_q[10] | (rem_sh >= {1'b0, b_q});
      rem_nx = rem_ge ? (rem_sh - {1'b0, b_q}) : rem_sh;
      quo_nx = {a_q[18:0], rem_ge};
   end

   // Next-state and datapath update for the handshake FSM.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      r_d     = r_q;
      dbz_d   = dbz_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d   = A;
               b_d   = B;
               rem_d = '0;
               cnt_d = '0;
               if (B == 10'd0) begin
                  q_d     = 20'hFFFFF;
                  r_d     = A[9:0];
                  dbz_d   = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            a_d   = quo_nx;
            rem_d = rem_nx;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_STEP) begin
               q_d     = quo_nx;
               r_d     = rem_nx[9:0];
               dbz_d   = 1'b0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset abandons any division in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
         r_q     <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         r_q     <= r_d;
         dbz_q   <= dbz_d;
      end
   end

   // Outputs come straight from registers only.
   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      Q         = q_q;
      R         = r_q;
      dbz       = dbz_q;
   end

endmodule

// File: tb/tb_bdiv20x10_seq.sv
// Bench for bdiv20x10_seq: scoreboard of expected results, pushed at drive
// time and popped when out_valid appears.
module tb_bdiv20x10_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] A;
   logic [9:0]  B;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] Q;
   logic [9:0]  R;
   logic        dbz;

   typedef struct packed {
      logic [19:0] q;
      logic [9:0]  r;
      logic        dbz;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   bdiv20x10_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Q         (Q),
      .R         (R),
      .dbz       (dbz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // Drive one pair, check latency and result, hold DONE for bp cycles, then release.
   task automatic run_div(input logic [19:0] a, input logic [9:0] b, input int bp);
      exp_t e;
      exp_t got;
      int   n;
      int   lat;
      if (b == 10'd0) begin
         e.q = 20'hFFFFF;
         e.r = a[9:0];
         e.dbz = 1'b1;
         lat = 1;
      end else begin
         e.q = a / {10'd0, b};
         e.r = 10'(a % {10'd0, b});
         e.dbz = 1'b0;
         lat = 21;
      end
      sb.push_back(e);
      A = a;
      B = b;
      in_valid = 1'b1;
      out_ready = 1'b0;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
         A = 20'($urandom);
         B = 10'($urandom);
      end while (!out_valid && n < 40);
      chk("latency", n, lat);
      got = sb.pop_front();
      chk("Q", {12'd0, Q}, {12'd0, got.q});
      chk("R", {22'd0, R}, {22'd0, got.r});
      chk("dbz", {31'd0, dbz}, {31'd0, got.dbz});
      for (int i = 0; i < bp; i++) begin
         A = 20'($urandom);
         B = 10'($urandom);
         in_valid = 1'b1;
         @(posedge clk);
         #1;
         chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
         chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
         chk("hold_Q", {12'd0, Q}, {12'd0, got.q});
         chk("hold_R", {22'd0, R}, {22'd0, got.r});
         chk("hold_dbz", {31'd0, dbz}, {31'd0, got.dbz});
      end
      out_ready = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("release_in_ready", {31'd0, in_ready}, 32'd1);
      chk("release_out_valid", {31'd0, out_valid}, 32'd0);
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("kept_Q", {12'd0, Q}, {12'd0, got.q});
      chk("kept_R", {22'd0, R}, {22'd0, got.r});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
      chk({tag, "_Q"}, {12'd0, Q}, 32'd0);
      chk({tag, "_R"}, {22'd0, R}, 32'd0);
      chk({tag, "_dbz"}, {31'd0, dbz}, 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      A = '0;
      B = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst = 1'b0;

      run_div(20'd1000, 10'd7, 0);
      run_div(20'hFFFFF, 10'd1, 0);
      run_div(20'hFFFFF, 10'd1023, 1);
      run_div(20'd5, 10'd10, 0);
      run_div(20'd0, 10'd3, 0);
      run_div(20'd1234, 10'd0, 0);
      run_div(20'd1000, 10'd7, 10);
      run_div(20'd1234, 10'd0, 10);

      // Reset in the middle of BUSY, after the tenth step.
      A = 20'd1000;
      B = 10'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk_reset_outputs("midbusy_reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_div(20'd1000, 10'd7, 0);

      for (int k = 0; k < 12; k++) begin
         logic [19:0] ra;
         logic [9:0]  rb;
         ra = 20'($urandom);
         rb = (k % 5 == 4) ? 10'd0 : 10'($urandom_range(1, 1023));
         run_div(ra, rb, k % 3);
      end

      chk("scoreboard_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
